handshake_pipeline: RTL and testbench

- Parametrised, clocked two-phase (transition-signalling) bundled-data pipeline of `DEPTH` Muller stages carrying a `DATA_W` payload.
- Each stage is a registered C-element rule: stage i toggles when upstream holds a new token and downstream has consumed the previous one.
- Sits between a two-phase producer and a two-phase consumer as an elastic buffer.
- Adds what a single C-element controller lacks: configurable depth, a data path, an occupancy count, full/empty flags and sticky protocol-error detection.

---
 rtl/handshake_pkg.sv | 13 +
 rtl/handshake_pipeline_if.sv | 31 +++
 rtl/hs_stage.sv | 41 ++++
 rtl/handshake_pipeline.sv | 82 ++++++++
 tb/tb_handshake_pipeline.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared fire rule and count-width helper for the two-phase pipeline
package handshake_pkg;

  // A stage toggles when upstream differs from it (new token) and downstream matches it (slot free).
  function automatic logic hs_fire(input logic prev_c, input logic self_c, input logic next_c);
    return (prev_c != self_c) && (next_c == self_c);
  endfunction

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/handshake_pipeline_if.sv
// rtl/handshake_pipeline_if.sv - producer/consumer two-phase bundle of the pipeline
interface handshake_pipeline_if
  import handshake_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
);

  logic                        Req_in;
  logic [DATA_W-1:0]           Data_in;
  logic                        Ack_out;
  logic                        Req_out;
  logic [DATA_W-1:0]           Data_out;
  logic                        Ack_in;
  logic [count_w(DEPTH)-1:0]   Count;
  logic                        Full;
  logic                        Empty;
  logic                        Proto_err;

  // master is the environment (producer and consumer together), slave is the pipeline.
  modport master (
    output Req_in, Data_in, Ack_in,
    input  Ack_out, Req_out, Data_out, Count, Full, Empty, Proto_err
  );

  modport slave (
    input  Req_in, Data_in, Ack_in,
    output Ack_out, Req_out, Data_out, Count, Full, Empty, Proto_err
  );

endinterface

// File: rtl/hs_stage.sv
// rtl/hs_stage.sv - one registered Muller stage: phase bit plus payload register
module hs_stage
  import handshake_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_c,
  input  logic              next_c,
  input  logic [DATA_W-1:0] d_in,
  output logic              c,
  output logic [DATA_W-1:0] d
);

  logic              c_q, c_d;
  logic [DATA_W-1:0] d_q, d_d;

  always_comb begin
    c_d = c_q;
    d_d = d_q;
    if (hs_fire(prev_c, c_q, next_c)) begin
      c_d = ~c_q;
      d_d = d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
      d_q <= '0;
    end else begin
      c_q <= c_d;
      d_q <= d_d;
    end
  end

  assign c = c_q;
  assign d = d_q;

endmodule

// File: rtl/handshake_pipeline.sv
// rtl/handshake_pipeline.sv - DEPTH-stage two-phase bundled-data elastic buffer
// with occupancy count, full/empty flags and a sticky protocol checker.
module handshake_pipeline
  import handshake_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  handshake_pipeline_if.slave  hs
);

  localparam int CW = count_w(DEPTH);

  logic [DEPTH-1:0]  c;
  logic [DATA_W-1:0] d [DEPTH];
  // cx[0] = Req_in, cx[i+1] = stage i, cx[DEPTH+1] = Ack_in
  logic [DEPTH+1:0]  cx;
  logic [CW-1:0]     cnt;

  logic req_q, req_d;
  logic ack_q, ack_d;
  logic err_q, err_d;

  assign cx = {hs.Ack_in, c, hs.Req_in};

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [DATA_W-1:0] d_in;
    if (i == 0) begin : g_first
      assign d_in = hs.Data_in;
    end else begin : g_rest
      assign d_in = d[i-1];
    end
    hs_stage #(.DATA_W(DATA_W)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .prev_c (cx[i]),
      .next_c (cx[i+2]),
      .d_in   (d_in),
      .c      (c[i]),
      .d      (d[i])
    );
  end

  // A stage holds a token exactly when its phase differs from the one downstream.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cx[i+1] != cx[i+2]) cnt = cnt + CW'(1);
    end
  end

  always_comb begin
    req_d = hs.Req_in;
    ack_d = hs.Ack_in;
    err_d = err_q;
    if ((hs.Req_in != req_q) && (req_q != c[0]))       err_d = 1'b1;
    if ((hs.Ack_in != ack_q) && (ack_q == c[DEPTH-1])) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      req_q <= req_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign hs.Ack_out   = c[0];
  assign hs.Req_out   = c[DEPTH-1];
  assign hs.Data_out  = d[DEPTH-1];
  assign hs.Count     = cnt;
  assign hs.Full      = (cnt == CW'(DEPTH));
  assign hs.Empty     = (cnt == '0);
  assign hs.Proto_err = err_q;

endmodule

// File: tb/tb_handshake_pipeline.sv
// tb/tb_handshake_pipeline.sv - scoreboard bench for handshake_pipeline at DEPTH 4 and DEPTH 1
module tb_handshake_pipeline;
  import handshake_pkg::*;

  logic       clk = 1'b0;
  logic       rst4 = 1'b1, rst1 = 1'b1, sel = 1'b0;
  logic       req_in = 1'b0, ack_in = 1'b0;
  logic [7:0] data_in = 8'h00;

  int depth = 4;
  int checks = 0, errors = 0, cyc = 0;
  byte unsigned exp_q[$];
  int   out_t[$];
  logic stream_rec = 1'b0;
  logic last_ro = 1'b0, last_ao = 1'b0;
  int   ack_toggles = 0;

  handshake_pipeline_if #(.DEPTH(4), .DATA_W(8)) if4 ();
  handshake_pipeline_if #(.DEPTH(1), .DATA_W(8)) if1 ();

  assign if4.Req_in = req_in;  assign if4.Data_in = data_in;  assign if4.Ack_in = ack_in;
  assign if1.Req_in = req_in;  assign if1.Data_in = data_in;  assign if1.Ack_in = ack_in;

  handshake_pipeline #(.DEPTH(4), .DATA_W(8)) dut4 (.clk(clk), .rst(rst4), .hs(if4));
  handshake_pipeline #(.DEPTH(1), .DATA_W(8)) dut1 (.clk(clk), .rst(rst1), .hs(if1));

  logic       ack_out, req_out, full, empty, perr, rst_cur;
  logic [7:0] data_out;
  logic [2:0] count;
  assign ack_out  = sel ? if1.Ack_out   : if4.Ack_out;
  assign req_out  = sel ? if1.Req_out   : if4.Req_out;
  assign data_out = sel ? if1.Data_out  : if4.Data_out;
  assign count    = sel ? 3'(if1.Count) : if4.Count;
  assign full     = sel ? if1.Full      : if4.Full;
  assign empty    = sel ? if1.Empty     : if4.Empty;
  assign perr     = sel ? if1.Proto_err : if4.Proto_err;
  assign rst_cur  = sel ? rst1 : rst4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (depth %0d, cycle %0d)", nm, act, exp, depth, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the consumer side presents a new token.
  always @(negedge clk) begin
    if (rst_cur) begin
      last_ro = 1'b0;
      last_ao = 1'b0;
      ack_toggles = 0;
    end else begin
      if (ack_out != last_ao) begin
        last_ao = ack_out;
        ack_toggles++;
      end
      if (req_out != last_ro) begin
        last_ro = req_out;
        if (stream_rec) out_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_token: got %0h expected no token", data_out);
        end else begin
          chk("out_token", data_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    if (sel) rst1 = 1'b1; else rst4 = 1'b1;
    req_in = 1'b0; ack_in = 1'b0; data_in = 8'h00;
    stream_rec = 1'b0;
    exp_q.delete();
    repeat (cycles) @(negedge clk);
    if (sel) rst1 = 1'b0; else rst4 = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_ack_out", ack_out, 0);
    chk("rst_req_out", req_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_proto_err", perr, 0);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (ack_out != req_in && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, ack_out == req_in, 1);
  endtask

  task automatic send(input logic [7:0] v);
    wait_ready("producer_ready");
    data_in = v;
    req_in  = ~req_in;
    exp_q.push_back(v);
    @(negedge clk);
  endtask

  task automatic single(input logic [7:0] v);
    send(v);
    chk("single_ack_edge1", ack_out, 1);
    chk("single_req_edge1", req_out, depth == 1);
    for (int n = 2; n <= depth; n++) begin
      @(negedge clk);
      chk("single_req_latency", req_out, n == depth);
    end
    chk("single_data_out", data_out, v);
    chk("single_count", count, 1);
  endtask

  task automatic fill_check(input int n_offer);
    for (int v = 1; v <= n_offer; v++) send(8'(v));
    repeat (3 * depth + 4) @(negedge clk);
    chk("fill_count", count, depth);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    chk("fill_ack_toggles", ack_toggles, depth);
    chk("fill_data_out", data_out, 8'h01);
    chk("fill_stalled", ack_out == req_in, 0);
  endtask

  initial begin
    // DEPTH = 4
    repeat (2) @(negedge clk);
    do_reset(2);
    check_reset();
    single(8'hA5);

    do_reset(2);
    fill_check(5);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (req_out == ack_in && n < 40) begin @(negedge clk); n++; end
      chk("drain_token_ready", req_out != ack_in, 1);
      ack_in = ~ack_in;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("drain_count", count, 1);
    chk("drain_data_out", data_out, 8'h05);
    chk("drain_all_seen", exp_q.size(), 0);
    chk("drain_ack_toggles", ack_toggles, 5);
    chk("drain_proto_err", perr, 0);

    do_reset(2);
    stream_rec = 1'b1;
    out_t.delete();
    fork
      begin
        for (int j = 0; j < 100; j++) send(8'($urandom_range(0, 255)));
      end
      begin
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || n < 10) && n < 2000) begin
          if (req_out != ack_in) ack_in = req_out;
          @(negedge clk);
          n++;
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("stream_all_seen", exp_q.size(), 0);
    chk("stream_tokens_out", out_t.size(), 100);
    if (out_t.size() == 100) chk("stream_rate", out_t[99] - out_t[0], 198);
    chk("stream_proto_err", perr, 0);
    stream_rec = 1'b0;

    do_reset(2);
    for (int v = 1; v <= 4; v++) send(8'(v));
    repeat (12) @(negedge clk);
    wait_ready("viol_full_ready");
    req_in = ~req_in;
    @(negedge clk);
    chk("viol_req_before", perr, 0);
    req_in = ~req_in;
    @(negedge clk);
    chk("viol_req_set", perr, 1);
    repeat (5) @(negedge clk);
    chk("viol_req_held", perr, 1);

    do_reset(2);
    ack_in = 1'b1;
    chk("viol_ack_before", perr, 0);
    @(negedge clk);
    chk("viol_ack_set", perr, 1);
    repeat (3) @(negedge clk);
    chk("viol_ack_held", perr, 1);

    do_reset(2);
    send(8'h11); send(8'h22); send(8'h33);
    repeat (12) @(negedge clk);
    chk("mid_count3", count, 3);
    do_reset(1);
    check_reset();
    single(8'h5A);

    // DEPTH = 1
    rst4 = 1'b1;
    sel = 1'b1;
    depth = 1;
    do_reset(2);
    check_reset();
    single(8'hA5);
    do_reset(2);
    fill_check(2);
    chk("d1_proto_err", perr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
